uart_cmd_frame_decoder: RTL

Parametrised command-frame decoder between the UART receiver and the SDRAM write FIFO and read/write controller. It parses framed write and read commands carrying an address, a length and an XOR checksum. Write payload bytes stream into the write FIFO. The block issues a write or read trigger with the latched address and length only when the frame checks out, and it reports length, checksum and timeout errors.

---
 rtl/uart_cmd_frame_decoder_if.sv | 30 +++
 rtl/uart_cmd_frame_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_decoder_if.sv
// Byte-stream and command/FIFO signals between the UART receiver, the frame
// decoder and the SDRAM write FIFO / read-write controller.
interface uart_cmd_frame_decoder_if #(
    parameter int ADDR_BYTES = 3
);
    logic [7:0]              rx_data;
    logic                    rx_flag;
    logic                    wr_trig;
    logic                    rd_trig;
    logic [8*ADDR_BYTES-1:0] cmd_addr;
    logic [7:0]              cmd_len;
    logic                    wfifo_wr_en;
    logic [7:0]              wfifo_wr_data;
    logic                    wfifo_flush;
    logic                    frame_err;
    logic [1:0]              err_code;
    logic                    busy;

    modport master (
        output rx_data, rx_flag,
        input  wr_trig, rd_trig, cmd_addr, cmd_len, wfifo_wr_en, wfifo_wr_data,
               wfifo_flush, frame_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_flag,
        output wr_trig, rd_trig, cmd_addr, cmd_len, wfifo_wr_en, wfifo_wr_data,
               wfifo_flush, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_frame_decoder.sv
// Parses header/address/length/payload/XOR-checksum command frames from the UART
// byte stream, streams write payload into the FIFO and triggers on valid frames.
module uart_cmd_frame_decoder #(
    parameter logic [7:0] WR_HEAD     = 8'h55,
    parameter logic [7:0] RD_HEAD     = 8'hAA,
    parameter int         ADDR_BYTES  = 3,
    parameter int         MAX_LEN     = 255,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_cmd_frame_decoder_if.slave   bus
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

    state_t          state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [AW-1:0]   addr_sh_q, addr_sh_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            wr_trig_q, wr_trig_d, rd_trig_q, rd_trig_d;
    logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic [7:0]      cmd_len_q, cmd_len_d;
    logic            wr_en_q, wr_en_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            flush_q, flush_d, ferr_q, ferr_d;
    logic [1:0]      err_code_q, err_code_d;

    logic len_bad, timeout, hdr_hit, addr_last, data_last;

    assign hdr_hit   = (bus.rx_data == WR_HEAD) || (bus.rx_data == RD_HEAD);
    assign len_bad   = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > 9'(MAX_LEN));
    assign addr_last = (cnt_q == 8'(ADDR_BYTES - 1));
    assign data_last = (cnt_q == len_q - 8'd1);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout   = (state_q != S_IDLE) && !bus.rx_flag && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.rx_flag) begin
            case (state_q)
                S_IDLE: if (hdr_hit)   state_d = S_ADDR;
                S_ADDR: if (addr_last) state_d = S_LEN;
                S_LEN:  state_d = len_bad ? S_IDLE : (is_wr_q ? S_DATA : S_CSUM);
                S_DATA: if (data_last) state_d = S_CSUM;
                S_CSUM: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        is_wr_d    = is_wr_q;
        addr_sh_d  = addr_sh_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        csum_d     = csum_q;
        tmo_d      = (state_q == S_IDLE || bus.rx_flag) ? '0 : tmo_q + TW'(1);
        wr_trig_d  = 1'b0;
        rd_trig_d  = 1'b0;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        flush_d    = 1'b0;
        ferr_d     = 1'b0;
        err_code_d = err_code_q;
        if (bus.rx_flag) begin
            case (state_q)
                S_IDLE: if (hdr_hit) begin
                    is_wr_d = (bus.rx_data == WR_HEAD);
                    csum_d  = 8'd0;
                    cnt_d   = 8'd0;
                end
                S_ADDR: begin
                    addr_sh_d = AW'({addr_sh_q, bus.rx_data});
                    csum_d    = csum_q ^ bus.rx_data;
                    cnt_d     = addr_last ? 8'd0 : cnt_q + 8'd1;
                end
                S_LEN: begin
                    len_d  = bus.rx_data;
                    csum_d = csum_q ^ bus.rx_data;
                    cnt_d  = 8'd0;
                    if (len_bad) begin
                        ferr_d     = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus.rx_data;
                    csum_d    = csum_q ^ bus.rx_data;
                    cnt_d     = cnt_q + 8'd1;
                end
                S_CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        wr_trig_d  = is_wr_q;
                        rd_trig_d  = !is_wr_q;
                        cmd_addr_d = addr_sh_q;
                        cmd_len_d  = len_q;
                    end else begin
                        ferr_d     = 1'b1;
                        err_code_d = 2'd2;
                        flush_d    = is_wr_q;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            ferr_d     = 1'b1;
            err_code_d = 2'd3;
            flush_d    = is_wr_q && (state_q == S_DATA || state_q == S_CSUM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr_q    <= 1'b0;
            addr_sh_q  <= '0;
            cnt_q      <= 8'd0;
            len_q      <= 8'd0;
            csum_q     <= 8'd0;
            tmo_q      <= '0;
            wr_trig_q  <= 1'b0;
            rd_trig_q  <= 1'b0;
            cmd_addr_q <= '0;
            cmd_len_q  <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'd0;
            flush_q    <= 1'b0;
            ferr_q     <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            is_wr_q    <= is_wr_d;
            addr_sh_q  <= addr_sh_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            wr_trig_q  <= wr_trig_d;
            rd_trig_q  <= rd_trig_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            flush_q    <= flush_d;
            ferr_q     <= ferr_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.wr_trig       = wr_trig_q;
    assign bus.rd_trig       = rd_trig_q;
    assign bus.cmd_addr      = cmd_addr_q;
    assign bus.cmd_len       = cmd_len_q;
    assign bus.wfifo_wr_en   = wr_en_q;
    assign bus.wfifo_wr_data = wr_data_q;
    assign bus.wfifo_flush   = flush_q;
    assign bus.frame_err     = ferr_q;
    assign bus.err_code      = err_code_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule
